// File: rtl/spi_master.sv
// Single-byte SPI master: one TX holding byte, one RX byte with ready/overrun
// flags. All four CPOL/CPHA modes, MSB first, one ss-low frame per byte.
// Frame timeline (ss low for exactly 18*CLK_DIV cycles):
//   SETUP  CLK_DIV cycles, sck idle
//   XFER   16 sck toggles, one at the end of each CLK_DIV period
//   HOLD   CLK_DIV cycles, sck idle; HOLD->GAP raises ss and lands the RX byte
//   GAP    SS_IDLE-1 cycles with ss high, then one IDLE cycle in which the next
//          frame can be launched, so ss stays high exactly SS_IDLE cycles.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int SS_IDLE = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data_reg,
  input  logic       tx_reg_we,
  output logic       tx_reg_empty,
  output logic [7:0] rx_data_reg,
  output logic       rx_data_ready,
  input  logic       rx_reg_re,
  input  logic       clear_error,
  output logic       rx_error,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  localparam int CMAX = (CLK_DIV > SS_IDLE) ? CLK_DIV : SS_IDLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_IDLE - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // cycles within the current period / gap
  logic [4:0]    edge_cnt;   // sck toggles already issued this frame
  logic [7:0]    tx_hold;
  logic [7:0]    shifter;    // TX bits leave at the top, RX bits enter at the bottom
  logic          sck_t;      // toggle reg; sck idles when this is 0
  logic          cpol_l;
  logic          cpha_l;
  logic          miso_q1;
  logic          miso_s;
  logic          period_end;
  logic          start;
  logic          completion;

  assign sck        = sck_t ^ cpol_l;
  assign period_end = (cnt == DIV_LAST);
  assign start      = enable && (state == S_IDLE) && !tx_reg_empty;
  assign completion = enable && (state == S_HOLD) && period_end;

  // Two-flop synchroniser on miso; CLK_DIV>=4 leaves room for its latency
  always_ff @(posedge sysclk) begin
    if (reset) begin
      miso_q1 <= 1'b0;
      miso_s  <= 1'b0;
    end else begin
      miso_q1 <= miso;
      miso_s  <= miso_q1;
    end
  end

  // TX holding register: a write always wins, a frame launch frees it
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_hold      <= 8'h00;
      tx_reg_empty <= 1'b1;
    end else if (tx_reg_we) begin
      tx_hold      <= tx_data_reg;
      tx_reg_empty <= 1'b0;
    end else if (start) begin
      tx_reg_empty <= 1'b1;
    end
  end

  // RX byte and flags: clear_error beats completion beats a plain read
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_data_reg   <= 8'h00;
      rx_data_ready <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      if (completion) rx_data_reg <= shifter;
      if (clear_error) begin
        rx_data_ready <= 1'b0;
        rx_error      <= 1'b0;
      end else if (completion) begin
        rx_data_ready <= 1'b1;
        // a read landing with the new byte means the old one was consumed
        if (rx_data_ready && !rx_reg_re) rx_error <= 1'b1;
      end else if (rx_reg_re) begin
        rx_data_ready <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered ss/mosi/busy and sck toggle generation
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      shifter  <= 8'h00;
      sck_t    <= 1'b0;
      cpol_l   <= cpol;
      cpha_l   <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
    end else if (!enable) begin
      // abort: drop the frame, keep sck parked at the idle level
      state    <= S_IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      shifter  <= 8'h00;
      sck_t    <= 1'b0;
      cpol_l   <= cpol;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // mode tracks the inputs while idle and freezes once a frame starts
          cpol_l <= cpol;
          cpha_l <= cpha;
          if (!tx_reg_empty) begin
            state    <= S_SETUP;
            cnt      <= '0;
            edge_cnt <= '0;
            shifter  <= tx_hold;
            ss       <= 1'b0;
            busy     <= 1'b1;
            // cpha=0 slaves sample on the first edge, so bit7 must be out now
            mosi     <= cpha ? 1'b0 : tx_hold[7];
          end
        end
        S_SETUP: begin
          if (period_end) begin
            state <= S_XFER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (period_end) begin
            cnt      <= '0;
            sck_t    <= ~sck_t;
            edge_cnt <= edge_cnt + 5'd1;
            // edge number is edge_cnt+1: cpha=0 samples odd edges, cpha=1 even
            if (edge_cnt[0] == cpha_l) begin
              shifter <= {shifter[6:0], miso_s};
            end else if (edge_cnt != 5'd15) begin
              // after a sample the next TX bit has moved up into bit 7
              mosi <= shifter[7];
            end
            if (edge_cnt == 5'd15) state <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (period_end) begin
            state <= S_GAP;
            cnt   <= '0;
            ss    <= 1'b1;
            mosi  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          sck_t <= 1'b0;
          ss    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: behavioural SPI slave on the wire,
// a byte-level flag model, randomized modes and data.
module tb_spi_master;

  localparam int CLK_DIV = 4;
  localparam int SS_IDLE = 4;
  localparam int FRAME   = 18 * CLK_DIV;

  logic       sysclk = 1'b0;
  logic       reset, enable, cpol, cpha;
  logic [7:0] tx_data_reg;
  logic       tx_reg_we, rx_reg_re, clear_error;
  logic       tx_reg_empty, rx_data_ready, rx_error, busy, sck, mosi, ss, miso;
  logic [7:0] rx_data_reg;

  int n_checks = 0;
  int n_fail   = 0;

  // expected RX state, advanced per completed byte
  logic [7:0] exp_rx;
  logic       exp_ready, exp_err;

  // slave model / wire monitor
  logic       loopback;
  logic [7:0] slv_load;
  logic [7:0] s_sh, s_rx;
  logic       s_miso = 1'b0;
  logic       ss_prev, sck_prev;
  int         edge_total = 0;
  int         rise_total = 0;

  assign miso = loopback ? mosi : s_miso;

  always #5 sysclk = ~sysclk;

  spi_master #(.CLK_DIV(CLK_DIV), .SS_IDLE(SS_IDLE)) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .cpol(cpol), .cpha(cpha),
    .tx_data_reg(tx_data_reg), .tx_reg_we(tx_reg_we), .tx_reg_empty(tx_reg_empty),
    .rx_data_reg(rx_data_reg), .rx_data_ready(rx_data_ready), .rx_reg_re(rx_reg_re),
    .clear_error(clear_error), .rx_error(rx_error), .busy(busy), .sck(sck),
    .mosi(mosi), .miso(miso), .ss(ss)
  );

  // SPI slave: loads on ss fall, samples/drives on sck edges per cpol/cpha
  always @(ss or sck) begin
    if (ss_prev === 1'b1 && ss === 1'b0) begin
      s_sh   = slv_load;
      s_rx   = 8'h00;
      s_miso = cpha ? 1'b0 : slv_load[7];
    end else if (ss === 1'b0 && sck !== sck_prev) begin
      edge_total++;
      if (sck === 1'b1) rise_total++;
      if ((sck !== cpol) ^ cpha) begin
        s_rx = {s_rx[6:0], mosi};
      end else if (!cpha) begin
        s_sh = s_sh << 1; s_miso = s_sh[7];
      end else begin
        s_miso = s_sh[7]; s_sh = s_sh << 1;
      end
    end
    ss_prev  = ss;
    sck_prev = sck;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge sysclk); #1;
  endtask

  task automatic write_tx(input logic [7:0] b);
    tx_data_reg = b; tx_reg_we = 1'b1; tick(); tx_reg_we = 1'b0;
  endtask

  task automatic pulse_read();
    rx_reg_re = 1'b1; tick(); rx_reg_re = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic wait_ss_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ss === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // n = cycles ss stayed low, counted from the first low sample
  task automatic wait_ss_high(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ss === 1'b1) begin ok = 1'b1; break; end
      tick(); n++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    tick(); tick();
  endtask

  task automatic do_frame(input logic [7:0] b, output int n, output bit ok);
    bit ok1, ok2;
    write_tx(b);
    wait_ss_low(ok1);
    wait_ss_high(n, ok2);
    ok = ok1 && ok2;
  endtask

  // a byte lands: flags follow the priority clear > completion > read
  function automatic void model_complete(input logic [7:0] b, input bit re, input bit clr);
    exp_rx = b;
    if (clr) begin
      exp_ready = 1'b0; exp_err = 1'b0;
    end else begin
      if (exp_ready && !re) exp_err = 1'b1;
      exp_ready = 1'b1;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [14:0] got, want;
    reset = 1'b1; enable = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_reg_we = 1'b0; rx_reg_re = 1'b0; clear_error = 1'b0;
    tx_data_reg = 8'h00; loopback = 1'b1; slv_load = 8'h00;
    repeat (3) tick();
    got  = {ss, sck, mosi, busy, tx_reg_empty, rx_data_reg, rx_data_ready, rx_error};
    want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_cpol0: got %h expected %h", got, want); end
    cpol = 1'b1; tick();
    n_checks++;
    if (sck !== 1'b1) begin n_fail++; $display("FAIL reset_cpol1_sck: got %b expected 1", sck); end
    cpol = 1'b0; reset = 1'b0; tick();
    enable = 1'b1; tick();
    exp_rx = 8'h00; exp_ready = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_mode0_loopback();
    int n, r0; bit ok1, ok2;
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b0; wait_idle();
    r0 = rise_total;
    write_tx(8'hA5);
    wait_ss_low(ok1);
    n_checks++;
    if (!ok1 || tx_reg_empty !== 1'b1) begin n_fail++; $display("FAIL m0_start: ss=%b empty=%b expected ss 0, empty 1", ss, tx_reg_empty); end
    wait_ss_high(n, ok2);
    model_complete(8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (!ok2 || n != FRAME) begin n_fail++; $display("FAIL m0_ss_low: got %0d cycles expected %0d", n, FRAME); end
    n_checks++;
    if (rise_total - r0 != 8) begin n_fail++; $display("FAIL m0_rises: got %0d expected 8", rise_total - r0); end
    n_checks++;
    if (rx_data_reg !== 8'hA5 || rx_data_ready !== 1'b1) begin n_fail++; $display("FAIL m0_rx: got %h/%b expected a5/1", rx_data_reg, rx_data_ready); end
    pulse_read();
    n_checks++;
    if (rx_data_ready !== exp_ready) begin n_fail++; $display("FAIL m0_read: ready %b expected %b", rx_data_ready, exp_ready); end
  endtask

  task automatic test_mode3_slave();
    int n, r0; bit ok;
    loopback = 1'b0; cpol = 1'b1; cpha = 1'b1; wait_idle();
    n_checks++;
    if (sck !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sck: got %b expected 1", sck); end
    slv_load = 8'h3C; r0 = rise_total;
    do_frame(8'hC3, n, ok);
    model_complete(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (!ok || n != FRAME) begin n_fail++; $display("FAIL m3_ss_low: got %0d expected %0d", n, FRAME); end
    n_checks++;
    if (rx_data_reg !== 8'h3C) begin n_fail++; $display("FAIL m3_master_rx: got %h expected 3c", rx_data_reg); end
    n_checks++;
    if (s_rx !== 8'hC3) begin n_fail++; $display("FAIL m3_slave_rx: got %h expected c3", s_rx); end
    n_checks++;
    if (sck !== 1'b1 || rise_total - r0 != 8) begin n_fail++; $display("FAIL m3_sck: idle %b rises %0d expected 1 and 8", sck, rise_total - r0); end
    pulse_read();
  endtask

  task automatic test_random_modes();
    int n; bit ok; logic [1:0] mode; logic [7:0] m, s;
    loopback = 1'b0;
    for (int it = 0; it < 10; it++) begin
      mode = 2'($urandom_range(0, 3));
      m = 8'($urandom); s = 8'($urandom);
      cpol = mode[1]; cpha = mode[0]; wait_idle();
      slv_load = s;
      do_frame(m, n, ok);
      model_complete(s, 1'b0, 1'b0);
      n_checks++;
      if (!ok || n != FRAME) begin n_fail++; $display("FAIL rnd%0d_ss_low mode %0d: got %0d expected %0d", it, mode, n, FRAME); end
      n_checks++;
      if (rx_data_reg !== exp_rx || rx_data_ready !== exp_ready || rx_error !== exp_err)
        begin n_fail++; $display("FAIL rnd%0d_master mode %0d: got %h/%b/%b expected %h/%b/%b", it, mode, rx_data_reg, rx_data_ready, rx_error, exp_rx, exp_ready, exp_err); end
      n_checks++;
      if (s_rx !== m) begin n_fail++; $display("FAIL rnd%0d_slave mode %0d: got %h expected %h", it, mode, s_rx, m); end
      n_checks++;
      if (sck !== cpol) begin n_fail++; $display("FAIL rnd%0d_idle_sck: got %b expected %b", it, sck, cpol); end
      pulse_read();
    end
  endtask

  task automatic test_overrun();
    int n; bit ok;
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b0; wait_idle();
    do_frame(8'h11, n, ok); model_complete(8'h11, 1'b0, 1'b0);
    wait_idle();
    do_frame(8'h22, n, ok); model_complete(8'h22, 1'b0, 1'b0);
    n_checks++;
    if (!ok || rx_error !== 1'b1 || rx_data_reg !== 8'h22 || rx_error !== exp_err)
      begin n_fail++; $display("FAIL overrun: err %b rx %h expected 1 22", rx_error, rx_data_reg); end
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    exp_ready = 1'b0; exp_err = 1'b0;
    n_checks++;
    if (rx_error !== 1'b0 || rx_data_ready !== 1'b0) begin n_fail++; $display("FAIL clear_error: err %b ready %b expected 0 0", rx_error, rx_data_ready); end
  endtask

  task automatic test_back_to_back();
    int n, g; bit ok1, ok2; logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b1; wait_idle();
    write_tx(a);
    wait_ss_low(ok1);
    write_tx(b);
    n_checks++;
    if (tx_reg_empty !== 1'b0) begin n_fail++; $display("FAIL b2b_pending: empty %b expected 0", tx_reg_empty); end
    wait_ss_high(n, ok2);
    model_complete(a, 1'b0, 1'b0);
    n_checks++;
    if (!ok1 || !ok2 || rx_data_reg !== a) begin n_fail++; $display("FAIL b2b_first_rx: got %h expected %h", rx_data_reg, a); end
    g = 0; rx_reg_re = 1'b1;
    while (ss === 1'b1 && g < 100) begin tick(); g++; rx_reg_re = 1'b0; end
    exp_ready = 1'b0;
    n_checks++;
    if (g != SS_IDLE) begin n_fail++; $display("FAIL b2b_gap: ss high %0d cycles expected %0d", g, SS_IDLE); end
    n_checks++;
    if (tx_reg_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", tx_reg_empty); end
    wait_ss_high(n, ok2);
    model_complete(b, 1'b0, 1'b0);
    n_checks++;
    if (!ok2 || n != FRAME || rx_data_reg !== b || rx_data_ready !== exp_ready || rx_error !== exp_err)
      begin n_fail++; $display("FAIL b2b_second: n %0d rx %h ready %b err %b expected %0d %h %b %b", n, rx_data_reg, rx_data_ready, rx_error, FRAME, b, exp_ready, exp_err); end
  endtask

  task automatic test_enable_abort();
    int n, e0, r0; bit ok, ok1; logic [7:0] c;
    c = 8'($urandom);
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b1; wait_idle();
    // leaves the previous byte unread: ready=1 going into the abort
    write_tx(8'($urandom));
    wait_ss_low(ok1);
    e0 = edge_total;
    for (int i = 0; i < 200; i++) begin
      if (edge_total - e0 >= 5) break;
      tick();
    end
    n_checks++;
    if (!ok1 || edge_total - e0 != 5) begin n_fail++; $display("FAIL abort_reach_edge5: got %0d edges expected 5", edge_total - e0); end
    enable = 1'b0; tick();
    n_checks++;
    if (ss !== 1'b1 || sck !== cpol || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: ss %b sck %b busy %b expected 1 %b 0", ss, sck, busy, cpol); end
    n_checks++;
    if (rx_data_reg !== exp_rx || rx_data_ready !== exp_ready || rx_error !== exp_err)
      begin n_fail++; $display("FAIL abort_flags: got %h/%b/%b expected %h/%b/%b", rx_data_reg, rx_data_ready, rx_error, exp_rx, exp_ready, exp_err); end
    enable = 1'b1; tick();
    r0 = rise_total;
    do_frame(c, n, ok);
    model_complete(c, 1'b0, 1'b0);
    n_checks++;
    if (!ok || n != FRAME || rise_total - r0 != 8) begin n_fail++; $display("FAIL abort_next_frame: n %0d rises %0d expected %0d 8", n, rise_total - r0, FRAME); end
    n_checks++;
    if (rx_data_reg !== c || rx_data_ready !== exp_ready || rx_error !== exp_err)
      begin n_fail++; $display("FAIL abort_next_rx: got %h/%b/%b expected %h/%b/%b", rx_data_reg, rx_data_ready, rx_error, c, exp_ready, exp_err); end
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    exp_ready = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_re_coincident();
    int n; bit ok; logic [7:0] x;
    x = 8'($urandom);
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b0; wait_idle();
    do_frame(8'h5C, n, ok); model_complete(8'h5C, 1'b0, 1'b0);
    wait_idle();
    write_tx(x);
    wait_ss_low(ok);
    repeat (FRAME - 1) tick();
    n_checks++;
    if (!ok || ss !== 1'b0) begin n_fail++; $display("FAIL coinc_frame_len: ss %b at cycle %0d expected 0", ss, FRAME - 1); end
    rx_reg_re = 1'b1; tick(); rx_reg_re = 1'b0;
    model_complete(x, 1'b1, 1'b0);
    n_checks++;
    if (ss !== 1'b1 || rx_data_ready !== exp_ready || rx_error !== exp_err || rx_data_reg !== x)
      begin n_fail++; $display("FAIL coinc_flags: ss %b ready %b err %b rx %h expected 1 1 0 %h", ss, rx_data_ready, rx_error, rx_data_reg, x); end
  endtask

  task automatic test_overwrite_and_mode_latch();
    int n; bit ok;
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b0; wait_idle();
    pulse_read();
    enable = 1'b0;
    write_tx(8'h5A); write_tx(8'h96);
    n_checks++;
    if (tx_reg_empty !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL overwrite_hold: empty %b busy %b expected 0 0", tx_reg_empty, busy); end
    enable = 1'b1;
    wait_ss_low(ok);
    // mode changes mid-frame must not disturb this frame
    cpol = 1'b1; cpha = 1'b1;
    wait_ss_high(n, ok);
    model_complete(8'h96, 1'b0, 1'b0);
    n_checks++;
    if (!ok || n != FRAME || rx_data_reg !== 8'h96 || rx_error !== exp_err)
      begin n_fail++; $display("FAIL overwrite_rx: n %0d rx %h err %b expected %0d 96 %b", n, rx_data_reg, rx_error, FRAME, exp_err); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [14:0] got, want; bit ok;
    loopback = 1'b1; cpol = 1'b1; cpha = 1'b0; wait_idle();
    write_tx(8'($urandom));
    wait_ss_low(ok);
    write_tx(8'($urandom));
    repeat (20) tick();
    n_checks++;
    if (!ok || busy !== 1'b1 || ss !== 1'b0 || tx_reg_empty !== 1'b0) begin n_fail++; $display("FAIL rst_pre: busy %b ss %b empty %b expected 1 0 0", busy, ss, tx_reg_empty); end
    reset = 1'b1; tick();
    got  = {ss, sck, mosi, busy, tx_reg_empty, rx_data_reg, rx_data_ready, rx_error};
    want = {1'b1, cpol, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_xfer: got %h expected %h", got, want); end
    reset = 1'b0; tick();
    exp_rx = 8'h00; exp_ready = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_random_modes();
    test_overrun();
    test_back_to_back();
    test_enable_abort();
    test_re_coincident();
    test_overwrite_and_mode_latch();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
